// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg: shared types and helpers for the DVP transmitter.
//   - dvp_tx_state_e : frame/line sequencer states
//   - RGB565_*       : eight colour-bar constants, white .. black
//   - bar_color()    : bar index -> RGB565
//   - cfg_legal()    : width/height legality against line timing
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_HFP,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFP
    } dvp_tx_state_e;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB565_WHITE;
            3'd1:    return RGB565_YELLOW;
            3'd2:    return RGB565_CYAN;
            3'd3:    return RGB565_GREEN;
            3'd4:    return RGB565_MAGENTA;
            3'd5:    return RGB565_RED;
            3'd6:    return RGB565_BLUE;
            default: return RGB565_BLACK;
        endcase
    endfunction

    // A line must hold front porch plus two bytes per pixel.
    function automatic logic cfg_legal(input logic [15:0] w, input logic [15:0] h,
                                       input int unsigned hfp, input int unsigned hts);
        logic [31:0] need;
        need = {15'd0, w, 1'b0} + 32'(hfp);
        return (w != 16'd0) && (h != 16'd0) && (need <= 32'(hts));
    endfunction

endpackage

// File: rtl/dvp_tx_colorbar.sv
// dvp_tx_colorbar: eight vertical colour bars across the active width.
//   col_i   : pixel column, 0 .. width_i-1
//   width_i : active pixels per line (non-zero while in use)
//   rgb_o   : RGB565 colour of bar floor(col_i*8/width_i)
module dvp_tx_colorbar
    import dvp_tx_pkg::*;
(
    input  logic [15:0] col_i,
    input  logic [15:0] width_i,
    output logic [15:0] rgb_o
);

    logic [18:0] scaled;
    logic [2:0]  idx;

    assign scaled = {col_i, 3'b000};
    // col < width keeps the quotient within 0..7
    assign idx    = 3'(scaled / {3'b000, width_i});
    assign rgb_o  = bar_color(idx);

endmodule

// File: rtl/dvp_tx_source.sv
// dvp_tx_source: DVP (OV5640-style) transmitter / camera emulator.
// Consumes RGB565 pixels on a valid/ready stream and launches them as
// high byte then low byte, one byte per clk_i, framed by cam_vsync_o and
// cam_href_o.
// Ports:
//   clk_i, reset_i (sync, active high), enable_i
//   resolution_width_i/depth_i : W/H, latched at frame start
//   pix_data_i, pix_valid_i, pix_ready_o : pixel stream (ready ignores valid)
//   cam_half_pixel_o, cam_href_o, cam_vsync_o : DVP link
//   frame_start_o, frame_done_o : one-cycle frame pulses
//   underrun_o (sticky), config_err_o
// Optional: define DVP_TX_TEST_PATTERN_EN to add pattern_sel_i, which
// replaces the stream with an internal 8-bar colour generator.
module dvp_tx_source
    import dvp_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int HTS         = 1896,
    parameter int HFP         = 20,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 10,
    parameter int VFP_LINES   = 10,
    parameter int CNT_W       = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [15:0]             resolution_width_i,
    input  logic [15:0]             resolution_depth_i,
    input  logic [2*DATA_WIDTH-1:0] pix_data_i,
    input  logic                    pix_valid_i,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic                    pattern_sel_i,
`endif
    output logic                    pix_ready_o,
    output logic [DATA_WIDTH-1:0]   cam_half_pixel_o,
    output logic                    cam_href_o,
    output logic                    cam_vsync_o,
    output logic                    frame_start_o,
    output logic                    frame_done_o,
    output logic                    underrun_o,
    output logic                    config_err_o
);

    localparam int PIX_W     = 2 * DATA_WIDTH;
    localparam int MAX_LINES = (VSYNC_LINES > VBP_LINES)
                             ? ((VSYNC_LINES > VFP_LINES) ? VSYNC_LINES : VFP_LINES)
                             : ((VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES);

    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_LINES * HTS - 1);
    localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(VBP_LINES * HTS - 1);
    localparam logic [CNT_W-1:0] VFP_LAST = CNT_W'(VFP_LINES * HTS - 1);
    localparam logic [CNT_W-1:0] HFP_LAST = CNT_W'(HFP - 1);

    // Phase counters must hold the longest blanking phase without wrapping.
    generate
        if ((HTS * MAX_LINES) > (1 << CNT_W) || HFP < 1 || VSYNC_LINES < 1 ||
            VBP_LINES < 1 || VFP_LINES < 1) begin : g_bad_timing
            $error("dvp_tx_source: timing parameters do not fit CNT_W");
        end
    endgenerate

    dvp_tx_state_e    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      line, line_n, h_last;
    logic [CNT_W-1:0] act_len, hb_len;
    logic             latch, cfg_ok, last_line;
    logic             hi_byte, lo_byte, src_valid;
    logic [PIX_W-1:0] src_data;
    logic [DATA_WIDTH-1:0] byte_d, hold_lo;

    assign cfg_ok    = cfg_legal(resolution_width_i, resolution_depth_i, HFP, HTS);
    assign last_line = (line == h_last);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            line    <= '0;
            h_last  <= '0;
            act_len <= '0;
            hb_len  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            line  <= line_n;
            if (latch) begin
                h_last  <= resolution_depth_i - 16'd1;
                act_len <= CNT_W'({resolution_width_i, 1'b0});
                hb_len  <= CNT_W'(HTS) - CNT_W'({resolution_width_i, 1'b0}) - CNT_W'(HFP);
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        line_n  = line;
        latch   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (enable_i && cfg_ok) begin
                    state_n = ST_VSYNC;
                    latch   = 1'b1;
                end
            end
            ST_VSYNC: if (cnt == VS_LAST) begin
                state_n = ST_VBP;
                cnt_n   = '0;
            end
            ST_VBP: if (cnt == VBP_LAST) begin
                state_n = ST_HFP;
                cnt_n   = '0;
                line_n  = '0;
            end
            ST_HFP: if (cnt == HFP_LAST) begin
                state_n = ST_ACTIVE;
                cnt_n   = '0;
            end
            ST_ACTIVE: if (cnt == act_len - CNT_W'(1)) begin
                cnt_n = '0;
                // a zero-length horizontal blank skips straight to the next line
                if (hb_len != '0) begin
                    state_n = ST_HBLANK;
                end else if (last_line) begin
                    state_n = ST_VFP;
                end else begin
                    state_n = ST_HFP;
                    line_n  = line + 16'd1;
                end
            end
            ST_HBLANK: if (cnt == hb_len - CNT_W'(1)) begin
                cnt_n = '0;
                if (last_line) begin
                    state_n = ST_VFP;
                end else begin
                    state_n = ST_HFP;
                    line_n  = line + 16'd1;
                end
            end
            ST_VFP: if (cnt == VFP_LAST) begin
                cnt_n = '0;
                if (enable_i && cfg_ok) begin
                    state_n = ST_VSYNC;
                    latch   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ---------------- pixel source ----------------
`ifdef DVP_TX_TEST_PATTERN_EN
    logic [15:0] w_lat, bar_rgb;

    always_ff @(posedge clk_i) begin
        if (reset_i)    w_lat <= '0;
        else if (latch) w_lat <= resolution_width_i;
    end

    dvp_tx_colorbar u_colorbar (
        .col_i   (16'(cnt >> 1)),
        .width_i (w_lat),
        .rgb_o   (bar_rgb)
    );

    assign src_data  = pattern_sel_i ? PIX_W'(bar_rgb) : pix_data_i;
    assign src_valid = pattern_sel_i | pix_valid_i;
`else
    assign src_data  = pix_data_i;
    assign src_valid = pix_valid_i;
`endif

    // ---------------- output comb ----------------
    // Even byte slots in ACTIVE launch a high byte on the coming edge.
    always_comb begin
        hi_byte     = (state == ST_ACTIVE) && !cnt[0];
        lo_byte     = (state == ST_ACTIVE) &&  cnt[0];
`ifdef DVP_TX_TEST_PATTERN_EN
        pix_ready_o = hi_byte && !pattern_sel_i;
`else
        pix_ready_o = hi_byte;
`endif
        byte_d = '0;
        if (hi_byte)      byte_d = src_valid ? src_data[PIX_W-1:DATA_WIDTH] : '0;
        else if (lo_byte) byte_d = hold_lo;
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cam_half_pixel_o <= '0;
            cam_href_o       <= 1'b0;
            cam_vsync_o      <= 1'b1;
            frame_start_o    <= 1'b0;
            frame_done_o     <= 1'b0;
            underrun_o       <= 1'b0;
            config_err_o     <= 1'b0;
            hold_lo          <= '0;
        end else begin
            cam_half_pixel_o <= byte_d;
            cam_href_o       <= (state == ST_ACTIVE);
            cam_vsync_o      <= (state == ST_IDLE) || (state == ST_VSYNC) || (state == ST_VFP);
            frame_start_o    <= (state == ST_VSYNC) && (cnt == '0);
            frame_done_o     <= lo_byte && (cnt == act_len - CNT_W'(1)) && last_line;
            if (hi_byte)
                hold_lo <= src_valid ? src_data[DATA_WIDTH-1:0] : '0;
            if (pix_ready_o && !pix_valid_i)
                underrun_o <= 1'b1;
            if (state == ST_IDLE)
                config_err_o <= !cfg_ok;
        end
    end

endmodule

// File: tb/tb_dvp_tx_source.sv
// tb_dvp_tx_source: randomized bench for dvp_tx_source with a frame-position
// reference model (HTS=40, HFP=4, one line each of VSYNC/VBP/VFP).
module tb_dvp_tx_source;

    localparam int HTS  = 40;
    localparam int HFP  = 4;
    localparam int VSL  = 1;
    localparam int VBPL = 1;
    localparam int VFPL = 1;
    localparam int BASE = (VSL + VBPL) * HTS;

    logic        tb_vgaClock = 1'b0;
    always #5 tb_vgaClock = ~tb_vgaClock;

    logic        reset_i, enable_i, pix_valid_i;
    logic [15:0] resolution_width_i, resolution_depth_i, pix_data_i;
    logic        pix_ready_o, cam_href_o, cam_vsync_o;
    logic        frame_start_o, frame_done_o, underrun_o, config_err_o;
    logic [7:0]  cam_half_pixel_o;
`ifdef DVP_TX_TEST_PATTERN_EN
    logic        pattern_sel_i = 1'b0;
`endif

    dvp_tx_source #(
        .DATA_WIDTH(8), .HTS(HTS), .HFP(HFP), .VSYNC_LINES(VSL),
        .VBP_LINES(VBPL), .VFP_LINES(VFPL), .CNT_W(16)
    ) dut (
        .clk_i              (tb_vgaClock),
        .reset_i            (reset_i),
        .enable_i           (enable_i),
        .resolution_width_i (resolution_width_i),
        .resolution_depth_i (resolution_depth_i),
        .pix_data_i         (pix_data_i),
        .pix_valid_i        (pix_valid_i),
`ifdef DVP_TX_TEST_PATTERN_EN
        .pattern_sel_i      (pattern_sel_i),
`endif
        .pix_ready_o        (pix_ready_o),
        .cam_half_pixel_o   (cam_half_pixel_o),
        .cam_href_o         (cam_href_o),
        .cam_vsync_o        (cam_vsync_o),
        .frame_start_o      (frame_start_o),
        .frame_done_o       (frame_done_o),
        .underrun_o         (underrun_o),
        .config_err_o       (config_err_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input int w, input int h);
        return (w > 0) && (h > 0) && (2 * w + HFP <= HTS);
    endfunction

    function automatic bit in_lines(input int rr, input int h);
        return (rr >= BASE) && (rr < BASE + h * HTS);
    endfunction

    function automatic bit m_hi(input int rr, input int w, input int h);
        int j;
        if (!in_lines(rr, h)) return 1'b0;
        j = (rr - BASE) % HTS;
        return (j >= HFP) && (j < HFP + 2 * w) && (((j - HFP) % 2) == 0);
    endfunction

    function automatic bit m_href(input int rr, input int w, input int h);
        int j;
        if (!in_lines(rr, h)) return 1'b0;
        j = (rr - BASE) % HTS;
        return (j >= HFP) && (j < HFP + 2 * w);
    endfunction

    // r: frame-relative output cycle (0 = frame_start_o); -1 = not in a frame
    int         r  = -1;
    int         mW = 0, mH = 0;
    logic [7:0] m_lo = 8'h00;
    bit         m_ur = 1'b0;

    always @(posedge tb_vgaClock) begin : model
        logic [15:0] d, w_in, h_in;
        logic        v, en, rs;
        logic [7:0]  exp_b;
        bit          hi;
        int          flen;
        d = pix_data_i; v = pix_valid_i; en = enable_i; rs = reset_i;
        w_in = resolution_width_i; h_in = resolution_depth_i;
        #1;
        if (rs) begin
            m_ur = 1'b0;
            r    = -1;
            chk("rst_vsync", cam_vsync_o, 1);
            chk("rst_href",  cam_href_o, 0);
            chk("rst_data",  cam_half_pixel_o, 0);
            chk("rst_pulses", {frame_start_o, frame_done_o}, 0);
            chk("rst_flags", {underrun_o, config_err_o, pix_ready_o}, 0);
        end else if (r < 0) begin
            chk("idle_vsync", cam_vsync_o, 1);
            chk("idle_href_data", {cam_href_o, cam_half_pixel_o}, 0);
            chk("idle_pulses", {frame_start_o, frame_done_o}, 0);
            chk("idle_ready", pix_ready_o, 0);
            chk("idle_underrun", underrun_o, m_ur);
            chk("idle_cfg_err", config_err_o, !m_legal(w_in, h_in));
            if (en && m_legal(w_in, h_in)) begin
                mW = w_in; mH = h_in; r = 0;
            end
        end else begin
            hi    = m_hi(r, mW, mH);
            exp_b = 8'h00;
            if (hi) begin
                exp_b = v ? d[15:8] : 8'h00;
                m_lo  = v ? d[7:0]  : 8'h00;
                if (!v) m_ur = 1'b1;
            end else if (m_href(r, mW, mH)) begin
                exp_b = m_lo;
            end
            chk("vsync", cam_vsync_o, !in_lines(r, mH) && !(r >= VSL * HTS && r < BASE));
            chk("href", cam_href_o, m_href(r, mW, mH));
            chk("data", cam_half_pixel_o, exp_b);
            chk("frame_start", frame_start_o, r == 0);
            chk("frame_done", frame_done_o, r == BASE + (mH - 1) * HTS + HFP + 2 * mW - 1);
            chk("ready", pix_ready_o, m_hi(r + 1, mW, mH));
            chk("underrun", underrun_o, m_ur);
            chk("cfg_err", config_err_o, 0);
            flen = (VSL + VBPL + mH + VFPL) * HTS;
            if (r == flen - 1) begin
                if (en && m_legal(w_in, h_in)) begin
                    mW = w_in; mH = h_in; r = 0;
                end else begin
                    r = -1;
                end
            end else begin
                r++;
            end
        end
    end

    // ---------------- stream driver ----------------
    bit seq_mode = 1'b1;
    int pix_k    = 0;

    always @(negedge tb_vgaClock) begin
        if (pix_ready_o) begin
            if (seq_mode) begin
                pix_data_i  = 16'h1234 + 16'(pix_k) * 16'h4444;
                pix_valid_i = (pix_k != 19);   // pixel 3 of line 0 in frame 2
            end else begin
                pix_data_i  = 16'($urandom);
                pix_valid_i = ($urandom_range(0, 19) != 0);
            end
            pix_k++;
        end else begin
            pix_data_i  = 16'($urandom);
            pix_valid_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- directed sequence ----------------
    logic [7:0] rb [200];
    logic       rv [200];
    logic       rh [200];
    logic       rd [200];

    task automatic wait_fs(input int lim, output int n);
        n = 0;
        do begin
            @(posedge tb_vgaClock); #1;
            n++;
        end while (!frame_start_o && n < lim);
        chk("frame_start_seen", frame_start_o, 1);
    endtask

    task automatic record_frame();
        for (int i = 0; i < 200; i++) begin
            if (i > 0) begin @(posedge tb_vgaClock); #1; end
            rb[i] = cam_half_pixel_o; rv[i] = cam_vsync_o;
            rh[i] = cam_href_o;       rd[i] = frame_done_o;
        end
    endtask

    initial begin
        int n, c0, c1, c2, hfirst, hcnt, fdi, fdc, fsc;
        bit ready_seen;
        reset_i = 1; enable_i = 0; pix_data_i = 0; pix_valid_i = 0;
        resolution_width_i = 16'd8; resolution_depth_i = 16'd2;
        repeat (3) @(posedge tb_vgaClock);
        #1;
        chk("reset_vsync", cam_vsync_o, 1);
        chk("reset_ready", pix_ready_o, 0);

        // illegal width: 2*20+4 > 40
        @(negedge tb_vgaClock);
        reset_i = 0; enable_i = 1; resolution_width_i = 16'd20;
        ready_seen = 0;
        repeat (10) begin
            @(posedge tb_vgaClock); #1;
            if (pix_ready_o) ready_seen = 1;
        end
        chk("cfg_err_set", config_err_o, 1);
        chk("cfg_err_vsync", cam_vsync_o, 1);
        chk("cfg_err_no_ready", ready_seen, 0);
        @(negedge tb_vgaClock);
        resolution_width_i = 16'd8;
        wait_fs(10, n);
        chk("start_latency", n, 2);

        // frame 1: sequential pixels, valid always high
        record_frame();
        c0 = 0; c1 = 0; c2 = 0; hfirst = -1; hcnt = 0; fdi = -1; fdc = 0;
        for (int i = 0; i < 200; i++) begin
            if (i < 40) c0 += rv[i]; else if (i < 160) c1 += rv[i]; else c2 += rv[i];
            if (rh[i]) begin hcnt++; if (hfirst < 0) hfirst = i; end
            if (rd[i]) begin fdc++; fdi = i; end
        end
        chk("f1_vsync_high", c0, 40);
        chk("f1_vsync_low", c1, 0);
        chk("f1_vfp_high", c2, 40);
        chk("f1_href_first", hfirst, 84);
        chk("f1_href_count", hcnt, 32);
        chk("f1_byte0", rb[84], 8'h12);
        chk("f1_byte1", rb[85], 8'h34);
        chk("f1_byte2", rb[86], 8'h56);
        chk("f1_byte3", rb[87], 8'h78);
        chk("f1_done_pos", fdi, 139);
        chk("f1_done_count", fdc, 1);
        chk("f1_no_underrun", underrun_o, 0);

        // frame 2: pixel 3 of line 0 missing
        wait_fs(10, n);
        chk("f2_back_to_back", n, 1);
        record_frame();
        chk("f2_drop_hi", rb[90], 8'h00);
        chk("f2_drop_lo", rb[91], 8'h00);
        chk("f2_next_pix", rb[92], 8'h67);
        chk("f2_underrun", underrun_o, 1);
        chk("f2_href_first", rh[84], 1);
        seq_mode = 0;

        // random geometry frames, including zero horizontal blank (W=18)
        for (int f = 0; f < 8; f++) begin
            wait_fs(600, n);
            repeat ($urandom_range(0, 150)) @(posedge tb_vgaClock);
            @(negedge tb_vgaClock);
            resolution_width_i = (f == 2) ? 16'd18 : 16'($urandom_range(1, 18));
            resolution_depth_i = 16'($urandom_range(1, 3));
        end

        // disable mid-ACTIVE: frame finishes, no restart
        @(negedge tb_vgaClock);
        resolution_width_i = 16'd8; resolution_depth_i = 16'd2;
        wait_fs(600, n);
        wait_fs(600, n);
        repeat (89) @(posedge tb_vgaClock);
        @(negedge tb_vgaClock);
        enable_i = 0;
        fsc = 0; fdc = 0;
        repeat (400) begin
            @(posedge tb_vgaClock); #1;
            fsc += frame_start_o; fdc += frame_done_o;
        end
        chk("dis_no_restart", fsc, 0);
        chk("dis_done_once", fdc, 1);
        chk("dis_idle_vsync", cam_vsync_o, 1);

        // reset mid-ACTIVE
        @(negedge tb_vgaClock);
        enable_i = 1;
        wait_fs(10, n);
        chk("restart_latency", n, 2);
        repeat (89) @(posedge tb_vgaClock);
        @(negedge tb_vgaClock);
        reset_i = 1;
        @(posedge tb_vgaClock); #1;
        chk("mid_rst_href", cam_href_o, 0);
        chk("mid_rst_vsync", cam_vsync_o, 1);
        chk("mid_rst_data", cam_half_pixel_o, 0);
        chk("mid_rst_flags", {underrun_o, config_err_o, frame_done_o}, 0);
        @(negedge tb_vgaClock);
        reset_i = 0;
        wait_fs(10, n);
        chk("post_rst_latency", n, 2);
        wait_fs(600, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
